reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter NREG, 8, number of Register instances driven.
REQ-003 Parameter DW, 8, register data width.
REQ-004 Parameter AW, 3, register address width.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 hold  in  1  CPU stall; while high, no request is accepted.
REQ-008 a_valid  in  1  requester A (ALU writeback) write request.
REQ-009 a_addr  in  AW  requester A target register.
REQ-010 a_data  in  DW  requester A write data.
REQ-011 a_ready  out  1  requester A accepted this cycle.
REQ-012 b_valid, b_addr, b_data, b_ready SHALL mirror the A ports for requester B (load unit).
REQ-013 reg_en  out  NREG  one-hot EN strobes to the Register instances.
REQ-014 reg_din  out  DW  shared din bus to all Register instances.
REQ-015 err_addr  out  1  one-cycle pulse: accepted write had address >= NREG.
REQ-016 conflict_cnt  out  8  saturating count of contended cycles.

Function
REQ-017 A transfer SHALL occur on a requester in a cycle when its valid and ready are both high.
REQ-018 The a_ready and b_ready outputs SHALL be combinational from the valid signals, hold, and the priority pointer, and at most one SHALL be high per cycle.
REQ-019 While hold=1, a_ready and b_ready SHALL be 0.
REQ-020 When hold=0 and only one valid is high, that requester's ready SHALL be 1.
REQ-021 When hold=0 and both valids are high, ready SHALL go to the requester named by the 1-bit pointer rr (0=A, 1=B), even if both target the same address.
REQ-022 After each transfer, rr SHALL point to the requester that did not transfer; rr SHALL be unchanged in cycles without a transfer.
REQ-023 A requester SHALL hold valid, addr and data stable until it is accepted; the block does not check this rule.
REQ-024 For a transfer in cycle N with addr < NREG:
  - reg_en SHALL equal the one-hot decode of addr in cycle N+1 only.
  - reg_din SHALL equal the data in cycle N+1.
  - Write latency is exactly 1 cycle.
REQ-025 For a transfer with addr >= NREG, reg_en SHALL stay 0 and err_addr SHALL be 1 in cycle N+1 only.
REQ-026 In cycles with no transfer in the previous cycle, reg_en SHALL be 0 and reg_din SHALL hold its last value.
REQ-027 Back-to-back transfers SHALL be supported with no bubble; sustained contention SHALL alternate A, B, A, B.
REQ-028 conflict_cnt SHALL increment by 1 in each cycle with a_valid=1, b_valid=1 and hold=0.
REQ-029 conflict_cnt SHALL saturate at 255 and not wrap.

Reset
REQ-030 With rst=1 at a clock edge, the next cycle SHALL have reg_en=0, reg_din=0, err_addr=0, conflict_cnt=0 and rr=0.
REQ-031 With rst=1, a_ready and b_ready SHALL be 0.
REQ-032 A transfer accepted in the cycle before rst is asserted SHALL be dropped: no reg_en strobe follows it.

Structure
REQ-033 Package regfile_pkg SHALL hold NREG, DW, AW and the requester-ID encoding (REQ_A=0, REQ_B=1).
REQ-034 A single sub-module onehot_dec (AW to NREG one-hot, with an out-of-range flag) SHALL do the address decode.

Verification
REQ-035 Single A write: a_valid=1, a_addr=3, a_data=0x5A, hold=0 -> a_ready=1 in cycle N; in N+1 reg_en=0x08, reg_din=0x5A.
REQ-036 Contention from reset: A(addr 1, 0x11) and B(addr 2, 0x22) both valid for 4 cycles with fresh data each cycle:
  - Grants SHALL be A, B, A, B.
  - reg_en SHALL be 0x02, 0x04, 0x02, 0x04, each one cycle after its grant.
  - conflict_cnt SHALL read 4.
REQ-037 Stall: both valid with hold=1 for 3 cycles, then hold=0 -> no ready during the stall; conflict_cnt unchanged during the stall; the first grant afterwards goes to A.
REQ-038 Saturation: 300 contended cycles -> conflict_cnt=255.
REQ-039 Bad address with NREG=6: b_addr=7 accepted -> reg_en=0 and err_addr=1 for one cycle.
REQ-040 Reset mid-operation: A accepted in cycle N, rst=1 in N+1 -> reg_en=0 in every cycle from N+1 onward until a new transfer; rr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing and requester-ID encoding for the register-file write path.
package regfile_pkg;

    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/onehot_dec.sv
// Address to one-hot decoder; flags addresses that have no register behind them.
module onehot_dec #(
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot,
    output logic            out_of_range
);

    always_comb begin
        onehot       = '0;
        out_of_range = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                onehot[i]    = 1'b1;
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter feeding one-hot write strobes and a shared
// data bus to a bank of registers, with a one-cycle write latency.
module reg_write_arbiter #(
    parameter int NREG = regfile_pkg::NREG,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    output logic [NREG-1:0] reg_en,
    output logic [DW-1:0]   reg_din,
    output logic            err_addr,
    output logic [7:0]      conflict_cnt,
    output logic            rr
);

    import regfile_pkg::*;

    // Handshake: a requester transfers in any cycle where its valid and ready
    // are both high. Ready is combinational from valid, hold, rst and rr_q, is
    // never high for both requesters, and never depends on ready itself.
    // Requesters keep valid/addr/data stable until they see ready.

    req_id_t        rr_q, rr_d;
    logic           wr_valid_q;
    logic [AW-1:0]  wr_addr_q;
    logic [NREG-1:0] dec_onehot;
    logic           dec_oor;
    logic           contended;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        rr_d    = rr_q;
        if (!rst && !hold) begin
            if (a_valid && (!b_valid || rr_q == REQ_A)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
        // Priority passes to whichever requester did not just transfer.
        if (a_ready) begin
            rr_d = REQ_B;
        end else if (b_ready) begin
            rr_d = REQ_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= REQ_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign contended = a_valid && b_valid && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            reg_din      <= '0;
            conflict_cnt <= '0;
        end else begin
            wr_valid_q <= a_ready || b_ready;
            if (a_ready) begin
                wr_addr_q <= a_addr;
                reg_din   <= a_data;
            end else if (b_ready) begin
                wr_addr_q <= b_addr;
                reg_din   <= b_data;
            end
            if (contended && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

    onehot_dec #(
        .AW   (AW),
        .NREG (NREG)
    ) u_dec (
        .addr         (wr_addr_q),
        .onehot       (dec_onehot),
        .out_of_range (dec_oor)
    );

    // Masking with rst drops a write accepted in the cycle just before reset.
    assign reg_en   = (wr_valid_q && !rst) ? dec_onehot : '0;
    assign err_addr = wr_valid_q && !rst && dec_oor;
    assign rr       = rr_q;

endmodule
